// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction fetch unit.
//   - FSM state encoding for ifetch
//   - default reset PC and the zero word
//   - FIFO geometry and the entry layout {addr, inst}
//   - MisalignTrapEn: compile-time hook driven by macro IFETCH_MISALIGN_TRAP_EN
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDrop = 2'd3
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned FifoWidth = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit MisalignTrapEn = 1'b1;
`else
  localparam bit MisalignTrapEn = 1'b0;
`endif

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- 2-entry, 64-bit FIFO holding fetched {addr, inst} pairs.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   push_i/wdata_i write request and data
//   pop_i          remove head (ignored when empty)
//   flush_i        empty the FIFO; wins over push and pop
//   rdata_o        head entry, zero when empty
//   full_o/empty_o/count_o  occupancy
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [FifoWidth-1:0] wdata_i,
  output logic [FifoWidth-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [1:0]           count_o
);

  logic [FifoWidth-1:0] mem_q [FifoDepth];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit: PC, single-outstanding ROM requests, 2-entry
// instruction buffer towards if_id, redirect handling.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   jump_en_i, jump_addr_i       redirect pulse and target
//   hold_i                       blocks new ROM requests only
//   rom_req_o, rom_addr_o        one-cycle fetch request and address
//   rom_rvalid_i, rom_rdata_i    ROM response
//   inst_valid_o, inst_ready_i   handshake towards if_id
//   inst_o, inst_addr_o          head instruction and its address (zero when empty)
//   misalign_o                   sticky misaligned-redirect flag (macro build only)
// Configuration: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects;
// otherwise the low two target bits are forced to zero.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic [31:0] inst_addr_o,
  output logic        misalign_o
`else
  output logic [31:0] inst_addr_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;

  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_wdata, fifo_rdata;
  logic         unused_fifo_count;

  logic [31:0]  jump_target;
  logic         jump_misaligned;
  logic         issue_block;

  // Without the trap the target is silently word-aligned; with it the raw
  // target is kept (issue is blocked afterwards anyway).
  assign jump_target     = MisalignTrapEn ? jump_addr_i : {jump_addr_i[31:2], 2'b00};
  assign jump_misaligned = MisalignTrapEn & jump_en_i & (jump_addr_i[1:0] != 2'b00);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misalign_d  = misalign_q | jump_misaligned;
  assign issue_block = misalign_q;
  assign misalign_o  = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign issue_block = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (jump_en_i) begin
      if (jump_misaligned) begin
        state_d = StReq;
      end else begin
        unique case (state_q)
          StIdle:  state_d = StIdle;
          StReq:   state_d = StReq;
          // A response in the jump cycle is the outstanding one: nothing left to drop.
          StWait:  state_d = rom_rvalid_i ? StReq : StDrop;
          StDrop:  state_d = rom_rvalid_i ? StReq : StDrop;
          default: state_d = StIdle;
        endcase
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StReq;
        StReq:   state_d = rom_req_o ? StWait : StReq;
        StWait:  state_d = rom_rvalid_i ? StReq : StWait;
        StDrop:  state_d = rom_rvalid_i ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_req_o = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      // Nothing is outstanding in StReq, so a non-full FIFO has a slot for the reply.
      StReq:   rom_req_o = ~jump_en_i & ~hold_i & ~fifo_full & ~issue_block;
      StWait:  fifo_push = rom_rvalid_i & ~jump_en_i;
      default: ;
    endcase
  end

  assign rom_addr_o = rom_req_o ? pc_q : ZeroWord;

  // ---------------------------------------------------------------------------
  // PC and address of the outstanding request
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (jump_en_i) begin
      pc_d = jump_target;
    end else if (rom_req_o) begin
      pc_d       = pc_incr(pc_q);
      req_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= ZeroWord;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  assign fifo_wdata   = '{addr: req_addr_q, inst: rom_rdata_i};
  assign inst_valid_o = ~fifo_empty & ~jump_en_i;
  assign fifo_pop     = inst_valid_o & inst_ready_i;

  ifetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (jump_en_i),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  // FIFO already presents zero when empty.
  assign inst_o      = fifo_rdata.inst;
  assign inst_addr_o = fifo_rdata.addr;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(ResetPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_rdata_i  (rom_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .inst_addr_o  (inst_addr_o),
    .misalign_o   (misalign_o)
`else
    .inst_addr_o  (inst_addr_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: fetch stream as a PC plus a queue of delivered {addr, inst}.
  logic [31:0] m_pc;
  logic [31:0] m_pend_addr;
  bit          m_live;     // the post-reset idle cycle is over
  bit          m_pend;     // a live request awaits its response
  bit          m_stale;    // a redirected-away request awaits its response
  bit          m_mis;      // misaligned redirect trapped
  bit          m_after_rst;
  logic [63:0] m_q[$];

  // ROM environment: one request at a time, configurable latency.
  bit          rom_busy;
  int          rom_cnt;
  logic [31:0] rom_a;

  task automatic model_reset();
    m_pc        = ResetPc;
    m_live      = 0;
    m_pend      = 0;
    m_stale     = 0;
    m_mis       = 0;
    m_after_rst = 1;
    m_q.delete();
    rom_busy    = 0;
  endtask

  task automatic step(input bit r, input bit hold, input bit ready, input bit jmp,
                      input logic [31:0] jaddr, input int lat);
    bit          exp_req, exp_valid, resp;
    logic [63:0] head;
    @(posedge clk);
    #1;
    rst          = r;
    hold_i       = hold;
    inst_ready_i = ready;
    jump_en_i    = jmp;
    jump_addr_i  = jaddr;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0;
    if (rom_busy) begin
      rom_cnt--;
      if (rom_cnt <= 0) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = rom_word(rom_a);
        rom_busy     = 0;
      end
    end
    #1;
    if (!r) begin
      model_reset();
      return;
    end
    resp      = rom_rvalid_i;
    exp_req   = m_live && !m_pend && !m_stale && !m_mis && !hold && !jmp && (m_q.size() < 2);
    exp_valid = (m_q.size() != 0) && !jmp;

    if (m_after_rst) begin
      check("rst_rom_addr", rom_addr_o, 32'h0);
      m_after_rst = 0;
    end
    check("rom_req", {31'b0, rom_req_o}, {31'b0, exp_req});
    if (exp_req) check("rom_addr", rom_addr_o, m_pc);
    check("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_valid});
    if (m_q.size() == 0) begin
      check("inst_zero", inst_o, 32'h0);
      check("addr_zero", inst_addr_o, 32'h0);
    end else if (exp_valid) begin
      head = m_q[0];
      check("inst", inst_o, head[31:0]);
      check("inst_addr", inst_addr_o, head[63:32]);
    end
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif

    if (rom_req_o) begin
      rom_busy = 1;
      rom_cnt  = lat;
      rom_a    = rom_addr_o;
    end

    if (exp_valid && ready) void'(m_q.pop_front());
    if (jmp) begin
      m_q.delete();
      if (m_pend) begin
        m_stale = !resp;
        m_pend  = 0;
      end else if (m_stale && resp) begin
        m_stale = 0;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_pc = jaddr;
      if (jaddr[1:0] != 2'b00) begin
        m_mis  = 1;
        m_live = 1;
      end
`else
      m_pc = {jaddr[31:2], 2'b00};
`endif
    end else begin
      if (m_pend && resp) begin
        m_q.push_back({m_pend_addr, rom_word(m_pend_addr)});
        m_pend = 0;
      end else if (m_stale && resp) begin
        m_stale = 0;
      end
      if (exp_req) begin
        m_pend      = 1;
        m_pend_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end
      m_live = 1;
    end
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned mode;
    mode = $urandom_range(0, 9);
    if (mode < 4)      return $urandom & 32'hFFFF_FFFC;
    else if (mode < 6) return 32'hFFFF_FFF0 | ($urandom & 32'hC);
    else if (mode < 8) return ($urandom & 32'h0000_03FC);
    else               return ($urandom & 32'h0000_03FC) | 32'($urandom_range(1, 3));
  endfunction

  initial begin
    rst          = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = 32'h0;
    hold_i       = 1'b0;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0;
    inst_ready_i = 1'b0;
    model_reset();

    // Streaming with latency 1 and a ready consumer.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 0, 1, 0, 0, 1);

    // Back-pressure: consumer stalls for long stretches.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 200; i++) step(1, 0, (i % 40) >= 15, 0, 0, 1 + (i % 3));

    // Redirects at fixed points, including PC wrap and jump coinciding with a response.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 32'h0000_0100, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 32'hFFFF_FFF4, 2);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 32'h0000_0102, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, 1);

    // Fully randomized traffic with occasional resets.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 14) == 0),
           rand_target(),
           $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (rst==0 resets on next rising clk edge).
REQ-004 jump_en_i  input  1  redirect request from ex, single-cycle pulse.
REQ-005 jump_addr_i  input  32  redirect target address.
REQ-006 hold_i  input  1  freezes request issue while high; responses still accepted.
REQ-007 rom_req_o  output  1  one-cycle fetch request pulse to instruction ROM.
REQ-008 rom_addr_o  output  32  fetch address, valid when rom_req_o=1.
REQ-009 rom_rvalid_i  input  1  response strobe, at least 1 cycle after request.
REQ-010 rom_rdata_i  input  32  instruction word, valid with rom_rvalid_i.
REQ-011 inst_valid_o  output  1  buffer head holds an instruction for if_id.
REQ-012 inst_ready_i  input  1  if_id accepts; transfer when inst_valid_o & inst_ready_i.
REQ-013 inst_o / inst_addr_o  output  32/32  head instruction and its address.
REQ-014 misalign_o  output  1  sticky misaligned-redirect flag (exists only under REQ-030).

Function
REQ-015 The block shall hold a PC register, a 2-entry instruction/address FIFO and an FSM with states IDLE, REQ, WAIT, DROP.
REQ-016 IDLE lasts exactly one cycle after reset release, then shall go to REQ.
REQ-017 In REQ, when hold_i==0 and FIFO free slots >=1, the block shall pulse rom_req_o with rom_addr_o=PC, set PC=PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), and go to WAIT; otherwise it shall stay in REQ with rom_req_o=0.
REQ-018 At most one request shall be outstanding; a slot is reserved at issue so a response never overflows the FIFO.
REQ-019 In WAIT, rom_rvalid_i shall push {rom_addr, rom_rdata_i} into the FIFO and return to REQ in the same cycle; the next request is issued no earlier than the following cycle.
REQ-020 inst_valid_o = FIFO non-empty & ~jump_en_i; a pop happens on inst_valid_o & inst_ready_i; simultaneous push and pop on a full FIFO shall be legal.
REQ-021 jump_en_i shall flush the FIFO, set PC=jump_addr_i, and move REQ->REQ, WAIT->DROP, DROP->DROP, IDLE->IDLE; jump has priority over every other event in that cycle.
REQ-022 A response arriving in the same cycle as jump_en_i shall be discarded; in that case WAIT goes to REQ, not DROP.
REQ-023 In DROP the next rom_rvalid_i shall be discarded, then the block returns to REQ; no request is issued in DROP.
REQ-024 rom_rvalid_i in IDLE or REQ shall be ignored.
REQ-025 hold_i shall not affect the FIFO, the outputs or an outstanding response.

Reset
REQ-026 On reset: PC=RESET_PC, state=IDLE, FIFO empty, rom_req_o=0, rom_addr_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, misalign_o=0.
REQ-027 Reset mid-transaction shall abandon the outstanding request; the ROM is reset on the same rst.
REQ-028 Data outputs shall read 0 whenever the FIFO is empty.

Configuration
REQ-029 Macro IFETCH_MISALIGN_TRAP_EN selects redirect-alignment behaviour.
REQ-030 When defined: jump_en_i with jump_addr_i[1:0]!=0 sets sticky misalign_o=1, flushes, and parks the FSM in REQ with issue blocked until reset.
REQ-031 When undefined: misalign_o is absent, and jump_addr_i[1:0] is forced to 2'b00.

Structure
REQ-032 The shared defines file shall hold the FSM state encodings, RESET_PC default, ZeroWord and the IFETCH_MISALIGN_TRAP_EN hook.
REQ-033 The FIFO shall be a sub-module, ifetch_fifo (2 entries, 64 bits, push/pop/flush/full/empty/count).

Verification
REQ-034 Reset release, ready=1, ROM latency 1 -> requests at 0x0,0x4,0x8; inst_addr_o 0x0 then 0x4 then 0x8, each with the matching ROM word.
REQ-035 inst_ready_i=0 for 10 cycles -> exactly 2 entries buffered, no third rom_req_o; ready=1 -> pops 0x0 then 0x4 in order.
REQ-036 jump_en_i with jump_addr 0x100 while in WAIT for 0x8 -> 0x8 response dropped; next request 0x100; first inst_addr_o = 0x100.
REQ-037 jump to 0x200 in the same cycle as rom_rvalid_i -> response discarded, no DROP state; next request 0x200 on the following cycle.
REQ-038 PC 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-039 Macro defined, jump to 0x102 -> misalign_o=1, no further rom_req_o until rst=0; macro undefined -> fetch at 0x100.
